multicycle_sequencer: RTL and testbench

- Parametrised successor to the fixed multicycle control state machine of the RISC-V datapath.
- Drives the 4-bit phase code that the fetch, decode, register file, ALU, memory and display submodules already decode.
- EX, WB and display delays are parameters instead of hard-wired auxiliary states.
- Adds a single-step mode, stall, and cycle/instruction counters for FPGA bring-up.

---
 rtl/multicycle_sequencer.sv | 177 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer for the RISC-V datapath.
// Emits the 4-bit phase code consumed by the fetch, decode, register file,
// ALU, memory and display blocks. The EX, WB and display delays are set by
// parameters. Adds single-step, stall and saturating performance counters
// for FPGA bring-up.
// The halt flag is named final_flag because "final" is a reserved word.
module multicycle_sequencer #(
  parameter int EX_WAIT   = 2,
  parameter int WB_WAIT   = 2,
  parameter int DISP_WAIT = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_mode,
  input  logic             step,
  input  logic             stall,
  input  logic             instr_zero,
  output logic [3:0]       phase,
  output logic             final_flag,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [3:0] {
    PH_IF    = 4'b0000,
    PH_ID    = 4'b0001,
    PH_EX    = 4'b0010,
    PH_MEM   = 4'b0011,
    PH_WB    = 4'b0100,
    PH_EXW   = 4'b0101,
    PH_WBW   = 4'b0110,
    PH_DISP  = 4'b1100,
    PH_SUMPC = 4'b1000,
    PH_FIM   = 4'b1001,
    PH_IDLE  = 4'b1010
  } phase_t;

  localparam logic [3:0]       EX_LOAD   = 4'(EX_WAIT);
  localparam logic [3:0]       WB_LOAD   = 4'(WB_WAIT);
  localparam logic [3:0]       DISP_LOAD = 4'(DISP_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  phase_t     state, state_next;
  logic [3:0] wait_cnt, wait_next;
  logic       halt_q, halt_next;
  logic       step_q;
  logic       step_rise;
  logic       retire;

  // A step request only counts on its rising edge, so a held step runs one instruction.
  assign step_rise = step & ~step_q;

  // The phase output is the state register itself.
  assign phase = state;

  // Next phase, wait counter and halt latch; stall freezes everything between IF and SUMPC.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    halt_next  = halt_q;
    retire     = 1'b0;
    case (state)
      PH_IDLE: begin
        if (run_mode || step_rise) begin
          state_next = PH_IF;
        end
      end
      PH_FIM: begin
        state_next = PH_FIM;
      end
      default: begin
        if (!stall) begin
          case (state)
            PH_IF: begin
              state_next = PH_ID;
            end
            PH_ID: begin
              if (instr_zero) begin
                state_next = PH_DISP;
                wait_next  = DISP_LOAD;
                halt_next  = 1'b1;
              end else begin
                state_next = PH_EX;
              end
            end
            PH_EX: begin
              if (EX_WAIT > 0) begin
                state_next = PH_EXW;
                wait_next  = EX_LOAD;
              end else begin
                state_next = PH_MEM;
              end
            end
            PH_EXW: begin
              if (wait_cnt <= 4'd1) begin
                state_next = PH_MEM;
              end else begin
                wait_next = wait_cnt - 4'd1;
              end
            end
            PH_MEM: begin
              state_next = PH_WB;
            end
            PH_WB: begin
              if (WB_WAIT > 0) begin
                state_next = PH_WBW;
                wait_next  = WB_LOAD;
              end else begin
                state_next = PH_DISP;
                wait_next  = DISP_LOAD;
              end
            end
            PH_WBW: begin
              if (wait_cnt <= 4'd1) begin
                state_next = PH_DISP;
                wait_next  = DISP_LOAD;
              end else begin
                wait_next = wait_cnt - 4'd1;
              end
            end
            PH_DISP: begin
              if (wait_cnt <= 4'd1) begin
                state_next = halt_q ? PH_FIM : PH_SUMPC;
              end else begin
                wait_next = wait_cnt - 4'd1;
              end
            end
            PH_SUMPC: begin
              retire     = 1'b1;
              state_next = run_mode ? PH_IF : PH_IDLE;
            end
            default: begin
              state_next = PH_IDLE;
            end
          endcase
        end
      end
    endcase
  end

  // State, wait counter, halt latch, step history and registered status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= PH_IDLE;
      wait_cnt   <= 4'd0;
      halt_q     <= 1'b0;
      step_q     <= 1'b0;
      final_flag <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_next;
      halt_q     <= halt_next;
      step_q     <= step;
      final_flag <= (state_next == PH_FIM);
      busy       <= (state_next != PH_IDLE) && (state_next != PH_FIM);
    end
  end

  // Saturating counters of retired instructions and busy cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      if (retire && !(&instr_count)) begin
        instr_count <= instr_count + CNT_ONE;
      end
      if (busy && !(&cycle_count)) begin
        cycle_count <= cycle_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard testbench for multicycle_sequencer. The stimulus thread queues
// the hand-computed per-cycle expectations for each scenario; a monitor pops
// one entry per cycle and compares it with the selected DUT instance.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst, run_mode, step, stall, instr_zero;
  logic [3:0]  phase0, phase1;
  logic        final0, final1, busy0, busy1;
  logic [15:0] ic0, cc0, ic1, cc1;

  typedef struct {
    int test;
    int idx;
    int dut;
    int ph;
    int ic;
    int cc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   test_id  = 0;
  int   push_idx = 0;
  int   instr_seq[11] = '{0, 1, 2, 5, 5, 3, 4, 6, 6, 12, 8};
  int   short_seq[7]  = '{0, 1, 2, 3, 4, 12, 8};

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  multicycle_sequencer dut0 (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step(step), .stall(stall),
    .instr_zero(instr_zero), .phase(phase0), .final_flag(final0), .busy(busy0),
    .instr_count(ic0), .cycle_count(cc0)
  );

  multicycle_sequencer #(.EX_WAIT(0), .WB_WAIT(0), .DISP_WAIT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step(step), .stall(stall),
    .instr_zero(instr_zero), .phase(phase1), .final_flag(final1), .busy(busy1),
    .instr_count(ic1), .cycle_count(cc1)
  );

  function void startTest(input int id);
    test_id  = id;
    push_idx = 0;
  endfunction

  // Queue one cycle of expected output; ic/cc of -1 mean "not checked this cycle".
  function void expectCycle(input int dut, input int ph, input int ic, input int cc);
    exp_t e;
    e.test = test_id;
    e.idx  = push_idx;
    e.dut  = dut;
    e.ph   = ph;
    e.ic   = ic;
    e.cc   = cc;
    exp_q.push_back(e);
    push_idx++;
  endfunction

  // Drive one cycle of inputs and advance to just after the next rising edge.
  task applyStimulus(input logic r, input logic rm, input logic s, input logic st,
                     input logic iz);
    rst        = r;
    run_mode   = rm;
    step       = s;
    stall      = st;
    instr_zero = iz;
    @(posedge clk);
    #1;
  endtask

  task doReset(input logic rm);
    applyStimulus(1'b0, rm, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  task drain(input logic rm);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      applyStimulus(1'b1, rm, 1'b0, 1'b0, 1'b0);
    end
    if (exp_q.size() > 0) begin
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
      $fatal(1, "[TB] scoreboard did not empty");
    end
  endtask

  task compareField(input string name, input exp_t e, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("[TB] FAIL t%0d[%0d] dut%0d %s: got %0d, expected %0d",
               e.test, e.idx, e.dut, name, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    int aph, afin, abusy, aic, acc;
    if (e.dut == 0) begin
      aph = int'(phase0); afin = int'(final0); abusy = int'(busy0);
      aic = int'(ic0);    acc  = int'(cc0);
    end else begin
      aph = int'(phase1); afin = int'(final1); abusy = int'(busy1);
      aic = int'(ic1);    acc  = int'(cc1);
    end
    compareField("phase", e, aph, e.ph);
    compareField("final", e, afin, (e.ph == 9) ? 1 : 0);
    compareField("busy", e, abusy, (e.ph == 9 || e.ph == 10) ? 0 : 1);
    if (e.ic >= 0) compareField("instr_count", e, aic, e.ic);
    if (e.cc >= 0) compareField("cycle_count", e, acc, e.cc);
  endtask

  // Monitor: one expected entry per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b0; run_mode = 1'b0; step = 1'b0; stall = 1'b0; instr_zero = 1'b0;

    // Test 1: defaults, three instructions then a zero instruction halts.
    $display("[TB] test 1: free-run and halt");
    startTest(1);
    doReset(1'b1);
    expectCycle(0, 10, 0, 0);
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 11; j++)
        expectCycle(0, instr_seq[j], (j == 0) ? k : -1, (j == 0) ? 11 * k : -1);
    expectCycle(0, 0, 3, 33);
    expectCycle(0, 1, -1, -1);
    expectCycle(0, 12, -1, -1);
    expectCycle(0, 9, 3, 36);
    expectCycle(0, 9, 3, 36);
    for (int i = 0; i < 35; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drain(1'b1);

    // Test 2: single-step with a one-cycle step pulse at cycle 5.
    $display("[TB] test 2: step pulse");
    startTest(2);
    doReset(1'b0);
    expectCycle(0, 10, 0, 0);
    for (int i = 1; i < 6; i++) expectCycle(0, 10, -1, -1);
    for (int j = 0; j < 11; j++) expectCycle(0, instr_seq[j], -1, -1);
    for (int i = 0; i < 3; i++) expectCycle(0, 10, 1, 11);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drain(1'b0);

    // Test 3: step held high for 40 cycles retires exactly one instruction.
    $display("[TB] test 3: step held");
    startTest(3);
    doReset(1'b0);
    expectCycle(0, 10, 0, 0);
    expectCycle(0, 10, -1, -1);
    for (int j = 0; j < 11; j++) expectCycle(0, instr_seq[j], -1, -1);
    expectCycle(0, 10, 1, 11);
    for (int i = 14; i < 41; i++) expectCycle(0, 10, -1, -1);
    for (int i = 0; i < 3; i++) expectCycle(0, 10, 1, 11);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drain(1'b0);

    // Test 4: zero wait parameters give a 7-cycle instruction.
    $display("[TB] test 4: minimum waits");
    startTest(4);
    doReset(1'b1);
    expectCycle(1, 10, 0, 0);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 7; j++)
        expectCycle(1, short_seq[j], (j == 0) ? k : -1, (j == 0) ? 7 * k : -1);
    expectCycle(1, 0, 2, 14);
    expectCycle(1, 1, -1, -1);
    expectCycle(1, 12, -1, -1);
    expectCycle(1, 9, 2, 17);
    expectCycle(1, 9, 2, 17);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drain(1'b1);

    // Test 5: stall for 4 cycles on entry to EXW stretches the instruction to 15.
    $display("[TB] test 5: stall in EXW");
    startTest(5);
    doReset(1'b1);
    expectCycle(0, 10, 0, 0);
    expectCycle(0, 0, -1, -1);
    expectCycle(0, 1, -1, -1);
    expectCycle(0, 2, -1, -1);
    for (int i = 0; i < 6; i++) expectCycle(0, 5, -1, -1);
    for (int j = 5; j < 11; j++) expectCycle(0, instr_seq[j], -1, -1);
    expectCycle(0, 0, 1, 15);
    expectCycle(0, 1, -1, -1);
    expectCycle(0, 12, -1, -1);
    expectCycle(0, 9, 1, 18);
    expectCycle(0, 9, 1, 18);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drain(1'b1);

    // Test 6: reset during WBW of the second instruction, then resume.
    $display("[TB] test 6: reset mid-instruction");
    startTest(6);
    doReset(1'b1);
    expectCycle(0, 10, 0, 0);
    for (int j = 0; j < 11; j++) expectCycle(0, instr_seq[j], -1, -1);
    expectCycle(0, 0, 1, 11);
    for (int j = 1; j < 7; j++) expectCycle(0, instr_seq[j], -1, -1);
    expectCycle(0, 6, 1, 18);
    expectCycle(0, 10, 0, 0);
    expectCycle(0, 0, 0, 0);
    expectCycle(0, 1, -1, -1);
    expectCycle(0, 2, 0, 2);
    for (int i = 0; i < 19; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
